// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the 8-digit seven-segment display between a timed alert
// source and three level-request view sources (fixed priority src1 > src2 > src3).
// Output frame {i0..i7}, i0 in [63:56]; 8'hFF per digit is a blank digit.
// Optional feature macro: DISP_ARB_BLINK_EN -- the alert frame blinks with a
// half-period of BLINK_CYC cycles instead of being shown steadily.
module disp_arbiter #(
  parameter int unsigned HOLD_CYC  = 100_000_000,
  parameter int unsigned DWELL     = 10_000_000,
  parameter int unsigned BLINK_CYC = 25_000_000,
  parameter int unsigned CNT_W     = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alert_pulse,
  input  logic [63:0] alert_frame,
  input  logic [2:0]  req,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  input  logic [63:0] frame3,
  output logic [63:0] disp_frame,
  output logic [3:0]  grant,
  output logic        alert_busy
);

  localparam logic [63:0]      Blank     = '1;
  localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DwellLoad = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StSrc,
    StAlert
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;   // 1..3 while in StSrc, 0 otherwise
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [63:0]      buf_q, buf_d;
  logic [63:0]      disp_q, disp_d;
  logic [3:0]       grant_q, grant_d;

  logic [1:0]       win;
  logic [63:0]      win_frame;
  logic [63:0]      own_frame;
  logic             own_req;
  logic             arb;
  logic [63:0]      alert_view;

`ifdef DISP_ARB_BLINK_EN
  localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_CYC - 1);

  logic [CNT_W-1:0] blink_q, blink_d;
  logic             vis_q, vis_d;     // alert phase: 1 = frame shown, 0 = blanked

  // Blink phase counter: restarts visible on every capture, runs while the alert holds.
  always_comb begin
    blink_d = blink_q;
    vis_d   = vis_q;
    if (alert_pulse) begin
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (state_q == StAlert && hold_q != '0) begin
      if (blink_q == BlinkLast) begin
        blink_d = '0;
        vis_d   = ~vis_q;
      end else begin
        blink_d = blink_q + CntOne;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      blink_q <= blink_d;
      vis_q   <= vis_d;
    end
  end

  assign alert_view = vis_d ? buf_q : Blank;
`else
  // BLINK_CYC only matters when the blink feature is built in.
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_CYC;
  assign alert_view       = buf_q;
`endif

  // Fixed-priority winner among the level requests (0 = nobody asking).
  always_comb begin
    win       = 2'd0;
    win_frame = Blank;
    if (req[0]) begin
      win       = 2'd1;
      win_frame = frame1;
    end else if (req[1]) begin
      win       = 2'd2;
      win_frame = frame2;
    end else if (req[2]) begin
      win       = 2'd3;
      win_frame = frame3;
    end
  end

  // Live frame and request level of the current owner.
  always_comb begin
    own_frame = Blank;
    own_req   = 1'b0;
    unique case (owner_q)
      2'd1: begin
        own_frame = frame1;
        own_req   = req[0];
      end
      2'd2: begin
        own_frame = frame2;
        own_req   = req[1];
      end
      2'd3: begin
        own_frame = frame3;
        own_req   = req[2];
      end
      default: begin
        own_frame = Blank;
        own_req   = 1'b0;
      end
    endcase
  end

  // Next-state: alert capture first, then per-state hold/dwell handling and arbitration.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    dwell_d = dwell_q;
    buf_d   = buf_q;
    disp_d  = disp_q;
    grant_d = grant_q;
    arb     = 1'b0;

    if (alert_pulse) begin
      // A pulse wins over any request activity in the same cycle.
      state_d = StAlert;
      owner_d = 2'd0;
      buf_d   = alert_frame;
      hold_d  = HoldLoad;
      grant_d = 4'b0001;
      disp_d  = alert_frame;
    end else begin
      unique case (state_q)
        StAlert: begin
          if (hold_q != '0) begin
            hold_d = hold_q - CntOne;
            disp_d = alert_view;
          end else begin
            // Last alert cycle: hand over in the same cycle, as from idle.
            arb = 1'b1;
          end
        end
        StSrc: begin
          if (!own_req) begin
            arb = 1'b1;
          end else if (dwell_q == '0 && win < owner_q) begin
            // Higher-priority preemption only once the dwell time is used up.
            arb = 1'b1;
          end else begin
            disp_d = own_frame;
            if (dwell_q != '0) begin
              dwell_d = dwell_q - CntOne;
            end
          end
        end
        StIdle: begin
          arb = 1'b1;
        end
        default: begin
          arb = 1'b1;
        end
      endcase

      if (arb) begin
        if (win != 2'd0) begin
          state_d = StSrc;
          owner_d = win;
          dwell_d = DwellLoad;
          grant_d = 4'b0001 << win;
          disp_d  = win_frame;
        end else begin
          state_d = StIdle;
          owner_d = 2'd0;
          dwell_d = '0;
          grant_d = 4'b0000;
          disp_d  = Blank;
        end
      end
    end
  end

  // State and output registers; reset aborts any alert or grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      hold_q  <= '0;
      dwell_q <= '0;
      buf_q   <= Blank;
      disp_q  <= Blank;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      dwell_q <= dwell_d;
      buf_q   <= buf_d;
      disp_q  <= disp_d;
      grant_q <= grant_d;
    end
  end

  assign disp_frame = disp_q;
  assign grant      = grant_q;
  assign alert_busy = grant_q[0];

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed scoreboard bench for disp_arbiter.
// Stimulus pushes the expected registered outputs (tagged with the clock cycle
// they must appear in); a monitor on the falling edge pops and compares.
module tb_disp_arbiter;

  localparam int unsigned Hold  = 8;
  localparam int unsigned Dwell = 4;
  localparam int unsigned Blink = 2;
  localparam logic [63:0] Ones  = '1;

  logic        clk;
  logic        rst;
  logic        alert_pulse;
  logic [63:0] alert_frame;
  logic [2:0]  req;
  logic [63:0] frame1;
  logic [63:0] frame2;
  logic [63:0] frame3;
  logic [63:0] disp_frame;
  logic [3:0]  grant;
  logic        alert_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          q_cyc[$];
  logic [3:0]  q_g[$];
  logic [63:0] q_f[$];
  string       q_n[$];

  disp_arbiter #(
    .HOLD_CYC (Hold),
    .DWELL    (Dwell),
    .BLINK_CYC(Blink),
    .CNT_W    (27)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alert_pulse(alert_pulse),
    .alert_frame(alert_frame),
    .req        (req),
    .frame1     (frame1),
    .frame2     (frame2),
    .frame3     (frame3),
    .disp_frame (disp_frame),
    .grant      (grant),
    .alert_busy (alert_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] g, input logic [63:0] f);
    tests++;
    if (grant !== g || disp_frame !== f || alert_busy !== g[0]) begin
      fails++;
      $display("FAIL %s: got grant=%b disp=%h busy=%b, want grant=%b disp=%h busy=%b",
               name, grant, disp_frame, alert_busy, g, f, g[0]);
    end
  endtask

  // Monitor: compare every expectation due in the cycle just clocked.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      check(q_n[0], q_g[0], q_f[0]);
      void'(q_cyc.pop_front());
      void'(q_g.pop_front());
      void'(q_f.pop_front());
      void'(q_n.pop_front());
    end
  end

  task automatic drive(input logic ap, input logic [63:0] af, input logic [2:0] r);
    alert_pulse = ap;
    alert_frame = af;
    req         = r;
  endtask

  task automatic expect_next(input logic [3:0] g, input logic [63:0] f, input string name);
    q_cyc.push_back(cyc + 1);
    q_g.push_back(g);
    q_f.push_back(f);
    q_n.push_back(name);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected alert display in alert cycle n (0 = capture cycle).
  function automatic logic [63:0] alert_view(input logic [63:0] f, input int n);
    logic blink_on;
    blink_on = 1'b0;
`ifdef DISP_ARB_BLINK_EN
    blink_on = 1'b1;
`endif
    return (blink_on && ((n / Blink) % 2 == 1)) ? Ones : f;
  endfunction

  task automatic alert_run(input logic [63:0] f, input int first, input int last,
                           input logic [2:0] r, input string name);
    for (int n = first; n <= last; n++) begin
      drive(1'b0, 64'h0, r);
      expect_next(4'b0001, alert_view(f, n), name);
      step();
    end
  endtask

  initial begin
    rst    = 1'b0;
    frame1 = 64'hF1F1_0000_0000_0011;
    frame2 = 64'hF2F2_0000_0000_0022;
    frame3 = 64'hF3F3_0000_0000_0033;
    drive(1'b0, 64'h0, 3'b000);
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 4'b0000, Ones);
    rst = 1'b1;

    // Idle with no requests.
    drive(1'b0, 64'h0, 3'b000);
    expect_next(4'b0000, Ones, "idle_no_req");
    step();
    expect_next(4'b0000, Ones, "idle_no_req");
    step();

    // src3 alone gets the display; its frame is tracked live.
    frame3 = 64'h0102_0304_0506_0708;
    drive(1'b0, 64'h0, 3'b100);
    expect_next(4'b1000, 64'h0102_0304_0506_0708, "src3_grant");
    step();
    frame3 = 64'h1112_1314_1516_1718;
    drive(1'b0, 64'h0, 3'b101);
    expect_next(4'b1000, 64'h1112_1314_1516_1718, "src3_track");
    step();
    frame3 = 64'h2122_2324_2526_2728;
    expect_next(4'b1000, 64'h2122_2324_2526_2728, "src3_dwell");
    step();
    expect_next(4'b1000, 64'h2122_2324_2526_2728, "src3_dwell");
    step();
    expect_next(4'b0010, 64'hF1F1_0000_0000_0011, "src1_preempt");
    step();

    // Lower-priority requests never preempt.
    drive(1'b0, 64'h0, 3'b111);
    expect_next(4'b0010, 64'hF1F1_0000_0000_0011, "no_lower_preempt");
    step();
    frame1 = 64'h1F1F_0000_0000_0111;
    expect_next(4'b0010, 64'h1F1F_0000_0000_0111, "no_lower_preempt");
    step();

    // Owner drops: re-arbitrate immediately regardless of dwell.
    drive(1'b0, 64'h0, 3'b110);
    expect_next(4'b0100, 64'hF2F2_0000_0000_0022, "drop_rearb");
    step();

    // Alert over src2: exactly Hold cycles, then back to src2.
    drive(1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 3'b110);
    expect_next(4'b0001, 64'hC0C0_C0C0_C0C0_C0C0, "alert_enter");
    step();
    alert_run(64'hC0C0_C0C0_C0C0_C0C0, 1, Hold - 1, 3'b110, "alert_hold");
    drive(1'b0, 64'h0, 3'b110);
    expect_next(4'b0100, 64'hF2F2_0000_0000_0022, "alert_exit_src2");
    step();

    // Retrigger at alert cycle 5: new frame, full hold again.
    drive(1'b1, 64'hA1A1_A1A1_A1A1_A1A1, 3'b000);
    expect_next(4'b0001, 64'hA1A1_A1A1_A1A1_A1A1, "retrig_first");
    step();
    alert_run(64'hA1A1_A1A1_A1A1_A1A1, 1, 4, 3'b000, "retrig_hold1");
    drive(1'b1, 64'hA2A2_A2A2_A2A2_A2A2, 3'b000);
    expect_next(4'b0001, 64'hA2A2_A2A2_A2A2_A2A2, "retrig_second");
    step();
    alert_run(64'hA2A2_A2A2_A2A2_A2A2, 1, Hold - 1, 3'b000, "retrig_hold2");

    // Request rising in the cycle the alert ends is honoured.
    drive(1'b0, 64'h0, 3'b001);
    expect_next(4'b0010, 64'h1F1F_0000_0000_0111, "rise_at_alert_end");
    step();
    drive(1'b0, 64'h0, 3'b000);
    expect_next(4'b0000, Ones, "drop_to_idle");
    step();

    // Alert pulse and request rise together: alert wins.
    drive(1'b1, 64'hA3A3_A3A3_A3A3_A3A3, 3'b100);
    expect_next(4'b0001, 64'hA3A3_A3A3_A3A3_A3A3, "alert_beats_req");
    step();
    alert_run(64'hA3A3_A3A3_A3A3_A3A3, 1, Hold - 1, 3'b100, "alert3_hold");
    drive(1'b0, 64'h0, 3'b100);
    expect_next(4'b1000, 64'h2122_2324_2526_2728, "alert3_exit_src3");
    step();
    expect_next(4'b1000, 64'h2122_2324_2526_2728, "src3_hold");
    step();

    // Asynchronous reset mid-grant clears outputs without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 4'b0000, Ones);
    step();
    drive(1'b0, 64'h0, 3'b000);
    rst = 1'b1;
    expect_next(4'b0000, Ones, "post_reset_idle");
    step();
    drive(1'b0, 64'h0, 3'b010);
    expect_next(4'b0100, 64'hF2F2_0000_0000_0022, "post_reset_src2");
    step();

    for (int i = 0; i < 4 && q_cyc.size() > 0; i++) step();
    if (q_cyc.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_cyc.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
